i2c_target_responder: RTL

//  I2C target (responder) for the downstream side of i2c_address_translator: recognises its own 7-bit address and ACKs it.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_target_responder_if.sv | 22 ++
 rtl/i2c_bus_sync.sv | 50 +++++
 rtl/i2c_target_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: field widths, R/W bit encoding and target FSM states.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_BYTE_W = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_target_responder_if.sv
// Local byte port of the I2C target: received bytes out, read bytes in, transfer status.
interface i2c_target_responder_if;
   import i2c_pkg::*;

   logic [I2C_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic [I2C_BYTE_W-1:0] tx_data;
   logic                  tx_req;
   logic                  busy;
   logic                  rw;

   modport slave (
      output rx_data, rx_valid, tx_req, busy, rw,
      input  tx_data
   );

   modport master (
      input  rx_data, rx_valid, tx_req, busy, rw,
      output tx_data
   );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and flags scl edges plus START/STOP conditions.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_pipe_q, scl_pipe_d;
   logic [SYNC_STAGES-1:0] sda_pipe_q, sda_pipe_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s;

   always_comb begin
      scl_pipe_d = {scl_pipe_q[SYNC_STAGES-2:0], scl_in};
      sda_pipe_d = {sda_pipe_q[SYNC_STAGES-2:0], sda_in};
      scl_s      = scl_pipe_q[SYNC_STAGES-1];
      sda_s      = sda_pipe_q[SYNC_STAGES-1];
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      scl_rise   = scl_s & ~scl_prev_q;
      scl_fall   = ~scl_s & scl_prev_q;
      // scl must be high on both sides of the sda transition to qualify
      start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_pipe_q <= '1;
         sda_pipe_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_pipe_q <= scl_pipe_d;
         sda_pipe_q <= sda_pipe_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with 7-bit address match: master writes land on rx_data, master reads fetch tx_data.
module i2c_target_responder
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h48,
   parameter int unsigned           SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   inout  wire                     scl,
   inout  wire                     sda,
   i2c_target_responder_if.slave   host
);

   i2c_tgt_state_t        state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [I2C_BYTE_W-1:0] shift_q, shift_d;
   logic                  sda_drv_q, sda_drv_d;
   logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tx_req_q, tx_req_d;
   logic                  busy_q, busy_d;
   logic                  rw_q, rw_d;

   logic                  sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [I2C_BYTE_W-1:0] shift_in;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl),
      .sda_in    (sda),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign scl = 1'bz;
   assign sda = sda_drv_q ? 1'b0 : 1'bz;

   assign host.rx_data  = rx_data_q;
   assign host.rx_valid = rx_valid_q;
   assign host.tx_req   = tx_req_q;
   assign host.busy     = busy_q;
   assign host.rw       = rw_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      sda_drv_d  = sda_drv_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;
      rw_d       = rw_q;
      shift_in   = {shift_q[I2C_BYTE_W-2:0], sda_s};

      if (!enable) begin
         state_d   = ST_IDLE;
         sda_drv_d = 1'b0;
         busy_d    = 1'b0;
         cnt_d     = '0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         sda_drv_d = 1'b0;
         busy_d    = 1'b0;
         cnt_d     = '0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         sda_drv_d = 1'b0;
         cnt_d     = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d = shift_in;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (shift_in[7:1] == TARGET_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        rw_d    = shift_in[0];
                        busy_d  = 1'b1;
                     end else begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end
            // sda_drv_q doubles as the ACK phase flag: low before the ACK bit, high during it
            ST_ADDR_ACK: begin
               if (scl_rise && sda_drv_q && rw_q == RW_READ) begin
                  shift_d  = host.tx_data;
                  tx_req_d = 1'b1;
               end
               if (scl_fall) begin
                  if (!sda_drv_q) begin
                     sda_drv_d = 1'b1;
                  end else if (rw_q == RW_READ) begin
                     sda_drv_d = ~shift_q[7];
                     shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     cnt_d     = 3'd1;
                     state_d   = ST_RD_BYTE;
                  end else begin
                     sda_drv_d = 1'b0;
                     state_d   = ST_WR_BYTE;
                  end
               end
            end
            ST_WR_BYTE: begin
               if (scl_rise) begin
                  shift_d = shift_in;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     state_d    = ST_WR_ACK;
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_drv_q) begin
                     sda_drv_d = 1'b1;
                  end else begin
                     sda_drv_d = 1'b0;
                     state_d   = ST_WR_BYTE;
                  end
               end
            end
            // cnt counts bits already driven; wrapping to 0 marks the fall that ends bit 8
            ST_RD_BYTE: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd0) begin
                     sda_drv_d = 1'b0;
                     state_d   = ST_RD_ACK;
                  end else begin
                     sda_drv_d = ~shift_q[7];
                     shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     cnt_d     = cnt_q + 3'd1;
                  end
               end
            end
            // stays here after a master ACK until the ACK-ending fall drives the next MSB
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_d = ST_WAIT_STOP;
                  end else begin
                     tx_req_d = 1'b1;
                     shift_d  = host.tx_data;
                  end
               end else if (scl_fall) begin
                  sda_drv_d = ~shift_q[7];
                  shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                  cnt_d     = 3'd1;
                  state_d   = ST_RD_BYTE;
               end
            end
            ST_WAIT_STOP: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         sda_drv_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         sda_drv_q  <= sda_drv_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
      end
   end

endmodule
